// File: rtl/decode_if.sv
// Decode-stage bus: fetch handshake, register-file read indices, decoded
// output register with its downstream handshake, and the writeback port.
//   i_valid/i_instr/o_ready   : fetch -> decode handshake
//   o_reg0_idx/o_reg1_idx     : operand read indices to regf
//   o_valid/i_ready           : decoded instruction handshake to downstream
//   o_op/o_rd/o_imm/o_wr_en   : decoded control fields
//   i_wb_en/i_wb_reg          : writeback retiring a destination
// Modport slave is the decode stage, master is its environment.
interface decode_if #(
    parameter int OPW = 6,
    parameter int IW  = 5
);
    logic           i_valid;
    logic [31:0]    i_instr;
    logic           o_ready;
    logic [IW-1:0]  o_reg0_idx;
    logic [IW-1:0]  o_reg1_idx;
    logic           o_valid;
    logic           i_ready;
    logic [OPW-1:0] o_op;
    logic [IW-1:0]  o_rd;
    logic [31:0]    o_imm;
    logic           o_wr_en;
    logic           i_wb_en;
    logic [IW-1:0]  i_wb_reg;

    modport slave (
        input  i_valid, i_instr, i_ready, i_wb_en, i_wb_reg,
        output o_ready, o_reg0_idx, o_reg1_idx, o_valid,
               o_op, o_rd, o_imm, o_wr_en
    );

    modport master (
        output i_valid, i_instr, i_ready, i_wb_en, i_wb_reg,
        input  o_ready, o_reg0_idx, o_reg1_idx, o_valid,
               o_op, o_rd, o_imm, o_wr_en
    );
endinterface

// File: rtl/decode.sv
// Instruction decode and issue stage, directly upstream of regf.
// Splits a 32-bit instruction into op/rd/rs0/rs1/imm, drives the regf read
// indices, and holds the decoded fields in an output register that lines up
// with regf's one-cycle registered read data. A per-register scoreboard marks
// destinations in flight and blocks issue of any instruction that reads or
// rewrites one of them until writeback retires it.
//   i_clk : clock, rising edge
//   i_rst : asynchronous, active-high reset
//   bus   : decode_if.slave (handshakes, read indices, decoded fields, writeback)
module decode #(
    parameter int OPW  = 6,
    parameter int NREG = 32
) (
    input  logic     i_clk,
    input  logic     i_rst,
    decode_if.slave  bus
);
    localparam int IW = $clog2(NREG);

    typedef struct packed {
        logic [OPW-1:0] op;
        logic [IW-1:0]  rd;
        logic [IW-1:0]  rs0;
        logic [IW-1:0]  rs1;
        logic [31:0]    imm;
        logic           wr_en;
    } dec_t;

    dec_t            dec;       // fields of the instruction presented now
    dec_t            held;      // output register
    logic            valid;
    logic [NREG-1:0] sb;
    logic [NREG-1:0] sb_next;
    logic            hz;
    logic            ready;
    logic            accept;

    // Field extraction; opcode bit 5 clear means the instruction writes rd.
    assign dec.op    = bus.i_instr[31:32-OPW];
    assign dec.rd    = bus.i_instr[25:21];
    assign dec.rs0   = bus.i_instr[20:16];
    assign dec.rs1   = bus.i_instr[15:11];
    assign dec.imm   = {{16{bus.i_instr[15]}}, bus.i_instr[15:0]};
    assign dec.wr_en = ~dec.op[OPW-1];

    // The rd term blocks a second write to a register still in flight (WAW).
    assign hz     = bus.i_valid & (sb[dec.rs0] | sb[dec.rs1] | (dec.wr_en & sb[dec.rd]));
    assign ready  = ~hz & (~valid | bus.i_ready);
    assign accept = bus.i_valid & ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            valid <= 1'b0;
            held  <= '0;
        end else if (accept) begin
            valid <= 1'b1;
            held  <= dec;
        end else if (bus.i_ready) begin
            valid <= 1'b0;
        end
    end

    // Clear first, then set, so an accept that claims the register being
    // retired in the same cycle leaves the bit set.
    always_comb begin
        // NOTE: default assigned before any conditional update so no path
        // leaves sb_next unassigned, which would infer a latch.
        sb_next = sb;
        if (bus.i_wb_en) sb_next[bus.i_wb_reg] = 1'b0;
        if (accept && dec.wr_en) sb_next[dec.rd] = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: the scoreboard is reset even though it is array-like
            // storage: stale set bits after reset would stall issue forever.
            sb <= '0;
        end else begin
            sb <= sb_next;
        end
    end

    // On accept regf must read the new operands; otherwise a stalled
    // instruction keeps re-reading its own so the data stays aligned.
    assign bus.o_reg0_idx = accept ? dec.rs0 : held.rs0;
    assign bus.o_reg1_idx = accept ? dec.rs1 : held.rs1;

    assign bus.o_ready = ready;
    assign bus.o_valid = valid;
    assign bus.o_op    = held.op;
    assign bus.o_rd    = held.rd;
    assign bus.o_imm   = held.imm;
    assign bus.o_wr_en = held.wr_en;
endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: directed scenarios followed by randomized
// traffic, all compared against a transaction-level model holding a set of
// pending destinations and the last issued instruction.
module tb_decode;
    logic i_clk = 1'b0;
    logic i_rst = 1'b1;

    always #5 i_clk = ~i_clk;

    decode_if bus ();

    decode dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    int total  = 0;
    int passed = 0;

    // Reference model state
    bit          pend [32];
    bit          m_valid;
    logic [5:0]  m_op;
    logic [4:0]  m_rd;
    logic [4:0]  m_rs0;
    logic [4:0]  m_rs1;
    logic [31:0] m_imm;
    logic        m_wr;

    // Values seen in the most recent cycle, for directed checks
    logic        last_rdy;
    logic [4:0]  last_idx0;
    logic [4:0]  last_idx1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs0, input logic [4:0] rs1,
                                       input logic [10:0] low);
        return {op, rd, rs0, rs1, low};
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] v);
        // Arithmetic sign extension: values at or above 0x8000 are negative.
        if (v >= 16'h8000) return 32'(v) - 32'h0001_0000;
        return 32'(v);
    endfunction

    task automatic model_reset();
        foreach (pend[k]) pend[k] = 1'b0;
        m_valid = 1'b0;
        m_op = '0; m_rd = '0; m_rs0 = '0; m_rs1 = '0; m_imm = '0; m_wr = 1'b0;
    endtask

    // One clock cycle: called 1 time unit after a rising edge, returns 1 time
    // unit after the next rising edge.
    task automatic cyc(input logic v, input logic [31:0] ins, input logic ir,
                       input logic wbe, input logic [4:0] wbr, input string tag);
        logic [5:0] op;
        logic [4:0] rd, rs0, rs1;
        bit         blocked, rdy, acc;
        op  = ins[31:26];
        rd  = ins[25:21];
        rs0 = ins[20:16];
        rs1 = ins[15:11];
        bus.i_valid  = v;
        bus.i_instr  = ins;
        bus.i_ready  = ir;
        bus.i_wb_en  = wbe;
        bus.i_wb_reg = wbr;
        @(negedge i_clk);
        blocked = v && (pend[rs0] || pend[rs1] || (op[5] == 1'b0 && pend[rd]));
        rdy     = !blocked && (!m_valid || ir);
        acc     = v && rdy;
        last_rdy  = bus.o_ready;
        last_idx0 = bus.o_reg0_idx;
        last_idx1 = bus.o_reg1_idx;
        chk({tag, ".ready"}, 32'(bus.o_ready), 32'(rdy));
        chk({tag, ".idx0"}, 32'(bus.o_reg0_idx), 32'(acc ? rs0 : m_rs0));
        chk({tag, ".idx1"}, 32'(bus.o_reg1_idx), 32'(acc ? rs1 : m_rs1));
        @(posedge i_clk);
        if (wbe) pend[wbr] = 1'b0;
        if (acc) begin
            m_valid = 1'b1;
            m_op = op; m_rd = rd; m_rs0 = rs0; m_rs1 = rs1;
            m_imm = sext16(ins[15:0]);
            m_wr  = (op < 6'd32);
            if (m_wr) pend[rd] = 1'b1;
        end else if (ir) begin
            m_valid = 1'b0;
        end
        #1;
        chk({tag, ".valid"}, 32'(bus.o_valid), 32'(m_valid));
        chk({tag, ".op"}, 32'(bus.o_op), 32'(m_op));
        chk({tag, ".rd"}, 32'(bus.o_rd), 32'(m_rd));
        chk({tag, ".imm"}, bus.o_imm, m_imm);
        chk({tag, ".wr_en"}, 32'(bus.o_wr_en), 32'(m_wr));
    endtask

    initial begin
        logic [31:0] ins_a, ins_b, ins_c;
        logic [31:0] pend_vec;

        bus.i_valid = 1'b0; bus.i_instr = '0; bus.i_ready = 1'b0;
        bus.i_wb_en = 1'b0; bus.i_wb_reg = '0;
        model_reset();

        // Reset state
        #12;
        chk("rst.valid", 32'(bus.o_valid), 0);
        chk("rst.op", 32'(bus.o_op), 0);
        chk("rst.imm", bus.o_imm, 0);
        chk("rst.wr_en", 32'(bus.o_wr_en), 0);
        chk("rst.ready", 32'(bus.o_ready), 1);
        chk("rst.idx0", 32'(bus.o_reg0_idx), 0);
        chk("rst.sb", dut.sb, 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        // Back-to-back stream (imm 0x8000 makes rs1 field 16)
        ins_a = {6'h00, 5'd1, 5'd2, 16'h8000};
        ins_b = mk(6'h20, 5'd4, 5'd5, 5'd6, 11'h0);
        cyc(1, ins_a, 1, 0, 0, "s0");
        chk("s0.acc", 32'(last_rdy), 1);
        chk("s0.imm_const", bus.o_imm, 32'hFFFF_8000);
        chk("s0.wr_const", 32'(bus.o_wr_en), 1);
        cyc(1, ins_b, 1, 0, 0, "s1");
        chk("s1.acc", 32'(last_rdy), 1);
        chk("s1.wr_const", 32'(bus.o_wr_en), 0);
        chk("s1.sb", dut.sb, 32'h0000_0002);
        cyc(0, 0, 1, 1, 5'd1, "drain0");

        // RAW on r7
        ins_a = mk(6'h00, 5'd7, 5'd8, 5'd10, 11'h0);
        ins_b = mk(6'h20, 5'd2, 5'd7, 5'd11, 11'h0);
        cyc(1, ins_a, 1, 0, 0, "raw.a");
        cyc(1, ins_b, 1, 0, 0, "raw.st0");
        chk("raw.stall0", 32'(last_rdy), 0);
        cyc(1, ins_b, 1, 0, 0, "raw.st1");
        cyc(1, ins_b, 1, 1, 5'd7, "raw.wb");
        chk("raw.stall_wb", 32'(last_rdy), 0);
        cyc(1, ins_b, 1, 0, 0, "raw.go");
        chk("raw.acc", 32'(last_rdy), 1);
        chk("raw.idx0_const", 32'(last_idx0), 7);

        // WAW on r9
        ins_a = mk(6'h00, 5'd9, 5'd13, 5'd14, 11'h0);
        ins_b = mk(6'h01, 5'd9, 5'd15, 5'd16, 11'h7);
        cyc(1, ins_a, 1, 0, 0, "waw.a");
        cyc(1, ins_b, 1, 0, 0, "waw.st");
        chk("waw.stall", 32'(last_rdy), 0);
        cyc(1, ins_b, 1, 1, 5'd9, "waw.wb");
        cyc(1, ins_b, 1, 0, 0, "waw.go");
        chk("waw.acc", 32'(last_rdy), 1);
        chk("waw.sb9", 32'(dut.sb[9]), 1);

        // Same-bit set and clear: set wins
        ins_c = mk(6'h00, 5'd12, 5'd17, 5'd18, 11'h0);
        cyc(1, ins_c, 1, 1, 5'd12, "sw");
        chk("sw.sb12", 32'(dut.sb[12]), 1);
        // Different bits set and clear together
        ins_c = mk(6'h00, 5'd13, 5'd19, 5'd20, 11'h0);
        cyc(1, ins_c, 1, 1, 5'd9, "db");
        chk("db.sb", dut.sb & 32'h0000_3200, 32'h0000_3000);

        // Backpressure
        ins_a = mk(6'h20, 5'd3, 5'd21, 5'd22, 11'h5);
        ins_b = mk(6'h21, 5'd4, 5'd23, 5'd24, 11'h0);
        cyc(1, ins_a, 1, 0, 0, "bp.a");
        for (int i = 0; i < 3; i++) begin
            cyc(1, ins_b, 0, 0, 0, "bp.hold");
            chk("bp.ready0", 32'(last_rdy), 0);
            chk("bp.idx0_held", 32'(last_idx0), 21);
            chk("bp.idx1_held", 32'(last_idx1), 22);
            chk("bp.op_held", 32'(bus.o_op), 32'h20);
        end
        cyc(1, ins_b, 1, 0, 0, "bp.go");
        chk("bp.acc", 32'(last_rdy), 1);
        cyc(0, 0, 1, 1, 5'd12, "drain1");
        cyc(0, 0, 1, 1, 5'd13, "drain2");

        // Fill scoreboard 0..15, then async reset mid-cycle
        for (int i = 0; i < 16; i++)
            cyc(1, mk(6'h00, 5'(i), 5'd20, 5'd21, 11'h0), 1, 0, 0, "fill");
        chk("fill.sb", dut.sb, 32'h0000_FFFF);
        chk("fill.valid", 32'(bus.o_valid), 1);
        #1;
        i_rst = 1'b1;
        #1;
        chk("arst.valid", 32'(bus.o_valid), 0);
        chk("arst.sb", dut.sb, 0);
        chk("arst.op", 32'(bus.o_op), 0);
        model_reset();
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        cyc(1, mk(6'h00, 5'd5, 5'd3, 5'd3, 11'h0), 1, 1, 5'd3, "post");
        chk("post.acc", 32'(last_rdy), 1);

        // Randomized traffic over a small register window to provoke hazards
        for (int n = 0; n < 400; n++) begin
            logic [5:0]  op;
            logic        wbe;
            logic [4:0]  wbr;
            int          start;
            op    = ($urandom_range(1) == 1) ? 6'h20 | 6'($urandom_range(31)) : 6'($urandom_range(31));
            ins_a = mk(op, 5'($urandom_range(7)), 5'($urandom_range(7)),
                       5'($urandom_range(7)), 11'($urandom));
            wbe   = 1'b0;
            wbr   = 5'($urandom_range(31));
            start = $urandom_range(31);
            for (int k = 0; k < 32; k++) begin
                if (pend[(start + k) % 32]) begin
                    wbr = 5'((start + k) % 32);
                    wbe = ($urandom_range(2) != 0);
                    break;
                end
            end
            if ($urandom_range(15) == 0) wbe = 1'b1;
            cyc(($urandom_range(4) != 0), ins_a, ($urandom_range(3) != 0), wbe, wbr, "rnd");
        end
        pend_vec = '0;
        foreach (pend[k]) pend_vec[k] = pend[k];
        chk("rnd.sb", dut.sb, pend_vec);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
